issue_queue: RTL

Dual-issue, age-ordered wakeup/select queue between rename/dispatch and the execute stage. It accepts up to two instructions per cycle with per-source ready bits taken from the busy table, and wakes pending sources on destination broadcasts. It selects up to two ready instructions, oldest first. It drives the `sel_inst1_dest`/`sel_inst2_dest` broadcast that clears busy-table bits, closing the loop that the busy table opens at map time.

---
 rtl/issue_queue_if.sv | 57 +++++
 rtl/issue_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/issue_queue_if.sv
// Dispatch/execute-facing bundle of the issue queue: dual enqueue, writeback
// wakeups, dual issue slots, the select-time wakeup broadcast and occupancy.
interface issue_queue_if #(
  parameter int DEPTH      = 8,
  parameter int REG_ADDR_W = 5,
  parameter int PAYLOAD_W  = 64
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  enq_valid1, enq_valid2, enq_ready;
  logic [REG_ADDR_W-1:0] enq_inst1_src1, enq_inst1_src2, enq_inst1_dest;
  logic                  enq_inst1_src1_ready, enq_inst1_src2_ready, enq_inst1_rf_we;
  logic [PAYLOAD_W-1:0]  enq_inst1_payload;
  logic [REG_ADDR_W-1:0] enq_inst2_src1, enq_inst2_src2, enq_inst2_dest;
  logic                  enq_inst2_src1_ready, enq_inst2_src2_ready, enq_inst2_rf_we;
  logic [PAYLOAD_W-1:0]  enq_inst2_payload;

  logic [REG_ADDR_W-1:0] wb_inst1_dest, wb_inst2_dest;

  logic                  iss_valid1, iss_valid2, iss_ready1, iss_ready2;
  logic [REG_ADDR_W-1:0] iss_inst1_dest, iss_inst2_dest;
  logic                  iss_inst1_rf_we, iss_inst2_rf_we;
  logic [PAYLOAD_W-1:0]  iss_inst1_payload, iss_inst2_payload;

  logic [REG_ADDR_W-1:0] sel_inst1_dest, sel_inst2_dest;
  logic [CNT_W-1:0]      count;

  modport slave (
    input  enq_valid1, enq_valid2,
    input  enq_inst1_src1, enq_inst1_src2, enq_inst1_dest,
    input  enq_inst1_src1_ready, enq_inst1_src2_ready, enq_inst1_rf_we, enq_inst1_payload,
    input  enq_inst2_src1, enq_inst2_src2, enq_inst2_dest,
    input  enq_inst2_src1_ready, enq_inst2_src2_ready, enq_inst2_rf_we, enq_inst2_payload,
    input  wb_inst1_dest, wb_inst2_dest,
    input  iss_ready1, iss_ready2,
    output enq_ready,
    output iss_valid1, iss_valid2,
    output iss_inst1_dest, iss_inst2_dest, iss_inst1_rf_we, iss_inst2_rf_we,
    output iss_inst1_payload, iss_inst2_payload,
    output sel_inst1_dest, sel_inst2_dest, count
  );

  modport master (
    output enq_valid1, enq_valid2,
    output enq_inst1_src1, enq_inst1_src2, enq_inst1_dest,
    output enq_inst1_src1_ready, enq_inst1_src2_ready, enq_inst1_rf_we, enq_inst1_payload,
    output enq_inst2_src1, enq_inst2_src2, enq_inst2_dest,
    output enq_inst2_src1_ready, enq_inst2_src2_ready, enq_inst2_rf_we, enq_inst2_payload,
    output wb_inst1_dest, wb_inst2_dest,
    output iss_ready1, iss_ready2,
    input  enq_ready,
    input  iss_valid1, iss_valid2,
    input  iss_inst1_dest, iss_inst2_dest, iss_inst1_rf_we, iss_inst2_rf_we,
    input  iss_inst1_payload, iss_inst2_payload,
    input  sel_inst1_dest, sel_inst2_dest, count
  );
endinterface

// File: rtl/issue_queue.sv
// Dual-issue, age-ordered collapsing issue queue: index 0 is oldest, valid
// entries are contiguous, and the two oldest ready entries are offered each cycle.
module issue_queue #(
  parameter int DEPTH      = 8,
  parameter int REG_ADDR_W = 5,
  parameter int PAYLOAD_W  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  issue_queue_if.slave  io
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  typedef struct packed {
    logic                 valid;
    reg_t                 src1;
    reg_t                 src2;
    logic                 rdy1;
    logic                 rdy2;
    reg_t                 dest;
    logic                 rf_we;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t               entries_q [DEPTH];
  entry_t               entries_d [DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 kill, enq_ready, enq_fire;
  logic [DEPTH-1:0]     sel1_hot, sel2_hot;
  logic                 found1, found2;
  logic                 iss_valid1, iss_valid2, fire1, fire2;
  reg_t                 iss1_dest, iss2_dest, sel1_dest, sel2_dest;
  logic                 iss1_we, iss2_we;
  logic [PAYLOAD_W-1:0] iss1_payload, iss2_payload;

  // Register 0 is never a real broadcast, so a zero source never matches.
  function automatic logic woken(input reg_t src, input reg_t w0, input reg_t w1,
                                 input reg_t w2, input reg_t w3);
    return (src != '0) && ((src == w0) || (src == w1) || (src == w2) || (src == w3));
  endfunction

  function automatic entry_t new_entry(input reg_t src1, input logic rdy1,
                                       input reg_t src2, input logic rdy2,
                                       input reg_t dest, input logic rf_we,
                                       input logic [PAYLOAD_W-1:0] payload,
                                       input reg_t w0, input reg_t w1,
                                       input reg_t w2, input reg_t w3);
    entry_t e;
    e.valid   = 1'b1;
    e.src1    = src1;
    e.src2    = src2;
    e.rdy1    = rdy1 | (src1 == '0) | woken(src1, w0, w1, w2, w3);
    e.rdy2    = rdy2 | (src2 == '0) | woken(src2, w0, w1, w2, w3);
    e.dest    = dest;
    e.rf_we   = rf_we;
    e.payload = payload;
    return e;
  endfunction

  assign kill      = reset | flush;
  assign enq_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign enq_fire  = enq_ready & io.enq_valid1 & ~kill;

  // Oldest-first select over registered state only.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    found1       = 1'b0;
    found2       = 1'b0;
    sel1_hot     = '0;
    sel2_hot     = '0;
    iss1_dest    = '0;
    iss2_dest    = '0;
    iss1_we      = 1'b0;
    iss2_we      = 1'b0;
    iss1_payload = '0;
    iss2_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && entries_q[i].rdy1 && entries_q[i].rdy2) begin
        if (!found1) begin
          found1       = 1'b1;
          sel1_hot[i]  = 1'b1;
          iss1_dest    = entries_q[i].dest;
          iss1_we      = entries_q[i].rf_we;
          iss1_payload = entries_q[i].payload;
        end else if (!found2) begin
          found2       = 1'b1;
          sel2_hot[i]  = 1'b1;
          iss2_dest    = entries_q[i].dest;
          iss2_we      = entries_q[i].rf_we;
          iss2_payload = entries_q[i].payload;
        end
      end
    end
  end

  assign iss_valid1 = found1 & ~kill;
  assign iss_valid2 = found2 & ~kill;
  assign fire1      = iss_valid1 & io.iss_ready1;
  assign fire2      = iss_valid2 & io.iss_ready2;
  assign sel1_dest  = (fire1 && iss1_we && iss1_dest != '0) ? iss1_dest : '0;
  assign sel2_dest  = (fire2 && iss2_we && iss2_dest != '0) ? iss2_dest : '0;

  // Compaction: survivors slide down in order, wakeups applied on the way,
  // then new instructions append right after the last survivor.
  always_comb begin
    entry_t           upd;
    logic             keep;
    logic [CNT_W-1:0] n_keep, n_rem, n_enq;
    entries_d = '{default: '0};
    upd       = '0;
    keep      = 1'b0;
    n_keep    = '0;
    n_rem     = CNT_W'(fire1) + CNT_W'(fire2);
    n_enq     = enq_fire ? (io.enq_valid2 ? CNT_W'(2) : CNT_W'(1)) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep     = entries_q[i].valid && !(fire1 && sel1_hot[i]) && !(fire2 && sel2_hot[i]);
      upd      = entries_q[i];
      upd.rdy1 = upd.rdy1 | woken(upd.src1, sel1_dest, sel2_dest,
                                  io.wb_inst1_dest, io.wb_inst2_dest);
      upd.rdy2 = upd.rdy2 | woken(upd.src2, sel1_dest, sel2_dest,
                                  io.wb_inst1_dest, io.wb_inst2_dest);
      if (keep) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (CNT_W'(j) == n_keep) entries_d[j] = upd;
        end
        n_keep = n_keep + CNT_W'(1);
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (enq_fire && CNT_W'(j) == n_keep)
        entries_d[j] = new_entry(io.enq_inst1_src1, io.enq_inst1_src1_ready,
                                 io.enq_inst1_src2, io.enq_inst1_src2_ready,
                                 io.enq_inst1_dest, io.enq_inst1_rf_we, io.enq_inst1_payload,
                                 sel1_dest, sel2_dest, io.wb_inst1_dest, io.wb_inst2_dest);
      if (enq_fire && io.enq_valid2 && CNT_W'(j) == n_keep + CNT_W'(1))
        entries_d[j] = new_entry(io.enq_inst2_src1, io.enq_inst2_src1_ready,
                                 io.enq_inst2_src2, io.enq_inst2_src2_ready,
                                 io.enq_inst2_dest, io.enq_inst2_rf_we, io.enq_inst2_payload,
                                 sel1_dest, sel2_dest, io.wb_inst1_dest, io.wb_inst2_dest);
    end
    count_d = count_q - n_rem + n_enq;
    if (flush) begin
      entries_d = '{default: '0};
      count_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      // NOTE: only the valid bits need reset; payload and tags are don't-care while invalid.
      for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign io.enq_ready         = enq_ready;
  assign io.iss_valid1        = iss_valid1;
  assign io.iss_valid2        = iss_valid2;
  assign io.iss_inst1_dest    = iss1_dest;
  assign io.iss_inst2_dest    = iss2_dest;
  assign io.iss_inst1_rf_we   = iss1_we;
  assign io.iss_inst2_rf_we   = iss2_we;
  assign io.iss_inst1_payload = iss1_payload;
  assign io.iss_inst2_payload = iss2_payload;
  assign io.sel_inst1_dest    = sel1_dest;
  assign io.sel_inst2_dest    = sel2_dest;
  assign io.count             = count_q;
endmodule
